multdiv_ctrl: RTL

Sequencing controller for the CPU's iterative multiply/divide unit. It accepts one MULT or DIV request at a time through a start/done handshake and latches the operands. It then runs a 32-step signed Booth multiply or signed restoring divide, one step per clock, and updates the architectural HI/LO registers read by MFHI/MFLO. The main control unit stalls on `busy` and resumes on `done`.

---
 rtl/multdiv_ctrl_if.sv | 21 ++
 rtl/multdiv_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/multdiv_ctrl_if.sv
// Request/result bundle between the main control unit and the multiply/divide sequencer.
// MULTDIV_DIVZERO_EXC_EN adds the div_zero result flag.
interface multdiv_ctrl_if;
    logic        start;
    logic        op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MULTDIV_DIVZERO_EXC_EN
    logic        div_zero;

    modport master (output start, op, A, B, input busy, done, hi, lo, div_zero);
    modport slave  (input start, op, A, B, output busy, done, hi, lo, div_zero);
`else
    modport master (output start, op, A, B, input busy, done, hi, lo);
    modport slave  (input start, op, A, B, output busy, done, hi, lo);
`endif
endinterface

// File: rtl/multdiv_ctrl.sv
// Iterative 32-step signed Booth multiply / restoring divide sequencer driving HI/LO.
// MULTDIV_DIVZERO_EXC_EN: DIV by zero skips iteration and raises div_zero with done.
module multdiv_ctrl (
    input  logic          clock,
    input  logic          reset,
    multdiv_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StMult, StDiv, StDone} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [32:0] m_q, m_d;
    // MULT: {acc[32:0], B, q-1}; DIV: {1'b0, rem[32:0], quo[31:0]}
    logic [65:0] work_q, work_d;
    logic        qneg_q, qneg_d, rneg_q, rneg_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
`ifdef MULTDIV_DIVZERO_EXC_EN
    logic        dz_q, dz_d;
`endif

    logic [31:0] mag_a, mag_b;
    logic [32:0] acc_sum, rem_sh, trial;
    logic [31:0] quo_sh, quo_fix, rem_fix;
    logic [65:0] pre_shift, mult_next, div_next;

    always_comb begin
        mag_a = bus.A[31] ? -bus.A : bus.A;
        mag_b = bus.B[31] ? -bus.B : bus.B;

        case (work_q[1:0])
            2'b01:   acc_sum = work_q[65:33] + m_q;
            2'b10:   acc_sum = work_q[65:33] - m_q;
            default: acc_sum = work_q[65:33];
        endcase
        pre_shift = {acc_sum, work_q[32:0]};
        mult_next = {pre_shift[65], pre_shift[65:1]};

        rem_sh = {work_q[63:32], work_q[31]};
        quo_sh = {work_q[30:0], 1'b0};
        trial  = rem_sh - m_q;
        if (trial[32]) begin
            div_next = {1'b0, rem_sh, quo_sh};
        end else begin
            div_next = {1'b0, trial, quo_sh | 32'd1};
        end
        quo_fix = qneg_q ? -div_next[31:0] : div_next[31:0];
        rem_fix = rneg_q ? -div_next[63:32] : div_next[63:32];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        work_d  = work_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MULTDIV_DIVZERO_EXC_EN
        dz_d    = dz_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    cnt_d  = 5'd0;
                    qneg_d = bus.A[31] ^ bus.B[31];
                    rneg_d = bus.A[31];
                    if (bus.op) begin
                        m_d     = {1'b0, mag_b};
                        work_d  = {34'd0, mag_a};
                        state_d = StDiv;
`ifdef MULTDIV_DIVZERO_EXC_EN
                        if (bus.B == 32'd0) begin
                            state_d = StDone;
                            dz_d    = 1'b1;
                        end
`endif
                    end else begin
                        m_d     = {bus.A[31], bus.A};
                        work_d  = {33'd0, bus.B, 1'b0};
                        state_d = StMult;
                    end
                end
            end
            StMult: begin
                work_d = mult_next;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    hi_d    = mult_next[64:33];
                    lo_d    = mult_next[32:1];
                    state_d = StDone;
                end
            end
            StDiv: begin
                work_d = div_next;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    hi_d    = rem_fix;
                    lo_d    = quo_fix;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
`ifdef MULTDIV_DIVZERO_EXC_EN
                dz_d    = 1'b0;
`endif
            end
            default: state_d = StIdle;
        endcase

        // Status outputs are registered copies of the next state.
        busy_d = (state_d == StMult) || (state_d == StDiv);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            m_q     <= 33'd0;
            work_q  <= 66'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
`ifdef MULTDIV_DIVZERO_EXC_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            work_q  <= work_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MULTDIV_DIVZERO_EXC_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
`ifdef MULTDIV_DIVZERO_EXC_EN
    assign bus.div_zero = dz_q;
`endif
endmodule
